// File: rtl/rst_sequencer_if.sv
// Reset sequencer signal bundle: the board-side reset/lock inputs and the
// released subsystem resets. The sequencer is the slave; the board (or a
// bench) drives the inputs through the master modport.
interface rst_sequencer_if;
    logic       SysRstN;
    logic       PllLocked;
    logic       RstClkN;
    logic       RstAdcN;
    logic       RstDspN;
    logic       InitDone;
    logic       LockFault;
    logic [2:0] StateOut;

    modport master (
        output SysRstN, PllLocked,
        input  RstClkN, RstAdcN, RstDspN, InitDone, LockFault, StateOut
    );

    modport slave (
        input  SysRstN, PllLocked,
        output RstClkN, RstAdcN, RstDspN, InitDone, LockFault, StateOut
    );
endinterface

// File: rtl/rst_sequencer.sv
// Power-up reset sequencer. Waits for the global reset to release and the
// PLL to hold lock for LockWait cycles, then releases clock, ADC and DSP
// resets StageGap cycles apart and finally raises InitDone. Losing lock
// after the clock domain is released re-asserts everything and latches
// LockFault until the global reset or RstBtn clears it.
module rst_sequencer #(
    parameter int unsigned LockWait = 1000,
    parameter int unsigned StageGap = 16
) (
    input  logic           CLK,
    input  logic           RstBtn,
    rst_sequencer_if.slave bus
);
    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        WAIT_LOCK = 3'd1,
        REL_CLK   = 3'd2,
        REL_ADC   = 3'd3,
        REL_DSP   = 3'd4,
        DONE      = 3'd5
    } state_e;

    // Terminal counts; the counter is only ever compared for equality.
    localparam logic [15:0] LOCK_LAST = 16'(LockWait - 1);
    localparam logic [15:0] GAP_LAST  = 16'(StageGap - 1);

    logic [1:0]  sys_sync_q;
    logic [1:0]  lock_sync_q;
    logic        sys_s;
    logic        lock_s;

    state_e      state_q, state_d;
    logic [15:0] cnt_q, cnt_d;
    logic        fault_q, fault_d;
    logic        rst_clk_q, rst_adc_q, rst_dsp_q, done_q;

    // Two-flop synchronizers for the asynchronous global reset and lock inputs.
    always_ff @(posedge CLK or negedge RstBtn) begin
        if (!RstBtn) begin
            sys_sync_q  <= '0;
            lock_sync_q <= '0;
        end else begin
            sys_sync_q  <= {sys_sync_q[0], bus.SysRstN};
            lock_sync_q <= {lock_sync_q[0], bus.PllLocked};
        end
    end

    assign sys_s  = sys_sync_q[1];
    assign lock_s = lock_sync_q[1];

    // Next-state and counter rules; global reset beats lock loss beats counting.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        fault_d = fault_q;
        if (!sys_s) begin
            state_d = IDLE;
            cnt_d   = '0;
            fault_d = 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d = WAIT_LOCK;
                    cnt_d   = '0;
                end
                WAIT_LOCK: begin
                    if (!lock_s) begin
                        cnt_d = '0;
                    end else if (cnt_q == LOCK_LAST) begin
                        state_d = REL_CLK;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                REL_CLK, REL_ADC, REL_DSP: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end else if (cnt_q == GAP_LAST) begin
                        state_d = (state_q == REL_CLK) ? REL_ADC :
                                  (state_q == REL_ADC) ? REL_DSP : DONE;
                        cnt_d   = '0;
                    end else begin
                        cnt_d = cnt_q + 16'd1;
                    end
                end
                DONE: begin
                    if (!lock_s) begin
                        state_d = WAIT_LOCK;
                        cnt_d   = '0;
                        fault_d = 1'b1;
                    end
                end
                default: begin
                    // Unused codes recover through IDLE with every reset held.
                    state_d = IDLE;
                    cnt_d   = '0;
                end
            endcase
        end
    end

    // State, counter and outputs all register on the same edge; outputs are
    // decoded from the next state so they change together with StateOut.
    always_ff @(posedge CLK or negedge RstBtn) begin
        if (!RstBtn) begin
            state_q   <= IDLE;
            cnt_q     <= '0;
            fault_q   <= 1'b0;
            rst_clk_q <= 1'b0;
            rst_adc_q <= 1'b0;
            rst_dsp_q <= 1'b0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            fault_q   <= fault_d;
            rst_clk_q <= state_d inside {REL_CLK, REL_ADC, REL_DSP, DONE};
            rst_adc_q <= state_d inside {REL_ADC, REL_DSP, DONE};
            rst_dsp_q <= state_d inside {REL_DSP, DONE};
            done_q    <= (state_d == DONE);
        end
    end

    assign bus.RstClkN   = rst_clk_q;
    assign bus.RstAdcN   = rst_adc_q;
    assign bus.RstDspN   = rst_dsp_q;
    assign bus.InitDone  = done_q;
    assign bus.LockFault = fault_q;
    assign bus.StateOut  = state_q;
endmodule

// File: doc/rst_sequencer.md
# rst_sequencer

Power-up reset sequencer for the ECT board. It consumes the active-low global reset pulse from the power-on reset generator, waits for the PLL to report a stable lock, then releases the subsystem resets in a fixed order: clock/PLL-fed logic, ADC front end, DSP/measurement core. It asserts `InitDone` when all three are released. If PLL lock is lost it re-asserts all subsystem resets and raises a sticky fault.

## Interface
**Parameters**
- `LockWait`, default 1000: consecutive synchronized-lock cycles required before the first release. Legal range is 1..65535.
- `StageGap`, default 16: cycles between successive reset releases, and between the last release and `InitDone`. Legal range is 1..65535.

**Ports**
- `CLK`, input, 1 bit: system clock.
- `RstBtn`, input, 1 bit: reset, asynchronous, active-low.
- `SysRstN`, input, 1 bit: global reset pulse from the power-on reset generator. Active-low; treated as asynchronous.
- `PllLocked`, input, 1 bit: PLL lock indicator. Asynchronous; high means locked.
- `RstClkN`, output, 1 bit: reset for PLL-clocked logic, active-low.
- `RstAdcN`, output, 1 bit: reset for the ADC front end, active-low.
- `RstDspN`, output, 1 bit: reset for the DSP/measurement core, active-low.
- `InitDone`, output, 1 bit: high when all resets are released.
- `LockFault`, output, 1 bit: sticky. Set when lock is lost after `RstClkN` has been released.
- `StateOut`, output, 3 bits: current state code, for debug.

## Operation
**Synchronization**
- `SysRstN` and `PllLocked` each pass through a 2-flop synchronizer, giving `sys_s` and `lock_s`.
- Both synchronizer chains reset to 0 on `RstBtn` low.

**State machine** (codes in brackets)
- IDLE[0]: all resets asserted, `InitDone`=0. Moves to WAIT_LOCK when `sys_s`=1.
- WAIT_LOCK[1]: 16-bit counter `cnt`.
  - `lock_s`=0: `cnt` is set to 0.
  - `lock_s`=1 and `cnt`==LockWait-1: move to REL_CLK and set `cnt` to 0.
  - `lock_s`=1 otherwise: increment `cnt`.
- REL_CLK[2]: `RstClkN`=1. `cnt` counts up; when `cnt`==StageGap-1, move to REL_ADC and set `cnt` to 0.
- REL_ADC[3]: `RstAdcN`=1. Same count rule as REL_CLK; moves to REL_DSP.
- REL_DSP[4]: `RstDspN`=1. Same count rule; moves to DONE.
- DONE[5]: `InitDone`=1. Stays in DONE while `lock_s`=1.
- Codes 6 and 7: move to IDLE on the next edge with all outputs asserted.

**Lock loss and fault**
- In REL_CLK, REL_ADC, REL_DSP or DONE, `lock_s`=0 has priority over the counting rules.
- On lock loss the next state is WAIT_LOCK, `cnt` is set to 0, all three resets are asserted, `InitDone` goes to 0 and `LockFault` is set to 1.

**Global reset and fault clearing**
- `sys_s`=0 in any state: synchronous return to IDLE. All resets are asserted, `cnt`=0 and `LockFault` is cleared.
- This rule has priority over every other transition.
- `LockFault` is cleared only by `RstBtn` low or by `sys_s`=0.

**Outputs**
- All outputs are registered and updated on the same edge as the state transition, with no combinational paths to outputs.
- Release order is always Clk, then Adc, then Dsp. Re-assertion is simultaneous for all three.

**Arithmetic**
- `cnt` is 16 bits unsigned and is compared for equality only, so it never wraps.
- `cnt` is cleared on every state change.

## Timing
**Reset values** (`RstBtn` low, asynchronous)
- State=IDLE, `cnt`=0.
- `RstClkN`=`RstAdcN`=`RstDspN`=0.
- `InitDone`=0, `LockFault`=0, `StateOut`=0.

**Nominal sequence**
- Let S be the first edge at which `SysRstN`=1 is sampled. WAIT_LOCK is entered at S+2.
- With `lock_s` already high, the edges are:
  - `RstClkN` rises at S+2+LockWait.
  - `RstAdcN` rises StageGap edges later.
  - `RstDspN` rises StageGap edges after that.
  - `InitDone` rises StageGap edges after that.

**Response latencies**
- Lock loss: outputs drop 3 edges after `PllLocked` falls (2 synchronizer edges plus 1 register edge).
- `SysRstN` falling: outputs drop 3 edges later.
- `RstBtn` asserted mid-sequence: all outputs drop immediately (asynchronous). After release, the block restarts from IDLE.

**Lock glitch**
- A lock drop shorter than one cycle that is missed by the synchronizer has no effect.
- A drop seen as `lock_s`=0 in WAIT_LOCK restarts the LockWait count from 0.

## Test plan
All scenarios use bench parameters LockWait=8, StageGap=4.

1. **Nominal power-up.** `RstBtn` pulsed low, `SysRstN` low for 50 cycles then high at edge S, `PllLocked`=1. Required: `RstClkN`↑ at S+10, `RstAdcN`↑ at S+14, `RstDspN`↑ at S+18, `InitDone`↑ at S+22, `LockFault`=0.
2. **Late lock.** `PllLocked`=0 until 20 cycles after S, then 1 at edge L. Required: state holds WAIT_LOCK, then `RstClkN`↑ at L+10.
3. **Lock glitch in WAIT_LOCK.** `PllLocked` drops for 2 cycles after 5 locked cycles. Required: count restarts; `RstClkN` rises 8 `lock_s`-high cycles after recovery.
4. **Lock loss in DONE.** `PllLocked` falls at edge F. Required: all resets 0, `InitDone`=0, `LockFault`=1 at F+3. After relock, the release sequence repeats and `LockFault` stays 1.
5. **Global reset mid-sequence.** `SysRstN` pulled low during REL_ADC. Required: all outputs 0 three edges later, state=IDLE, `LockFault` cleared.
6. **Asynchronous button.** `RstBtn` low between clock edges in DONE. Required: all outputs 0 with no clock edge. On release with `SysRstN`=1 and `PllLocked`=1, the scenario 1 timing repeats measured from the first sampled edge.
